fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Each cycle it takes the current PC, issues a read to the synchronous instruction memory (1-cycle read latency) and captures the returned word together with its PC.
- Captured pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake.
- Back-pressures the PC via pc_stall and discards wrong-path instructions on a taken branch.

---
 rtl/fetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage that sits directly after the program counter.
//
// Each cycle in which it has credit, the block issues a read to a synchronous
// instruction memory with one cycle of read latency. It captures the returned word
// together with its PC into a small FIFO. Decode takes entries from the head of the
// FIFO over a valid/ready handshake. A taken branch (flush) throws away everything
// that has been fetched but not yet consumed.
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   pc              current PC from the program counter
//   flush           taken branch/jump; drops queued and in-flight work
//   pc_stall        PC must hold this cycle (no fetch issued)
//   imem_addr       instruction-memory address (= pc)
//   imem_req        read request this cycle
//   imem_rdata      read data, valid the cycle after imem_req
//   instr, instr_pc head-of-queue instruction and its PC
//   instr_valid     head entry valid
//   instr_ready     decode accepts the head this cycle
//
// Optional: define FETCH_PERF_EN to add the saturating counters perf_stall_cnt
// and perf_flush_cnt.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    output logic             pc_stall,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt,
`endif
    input  logic             instr_ready
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             inflight_q;
    logic [WIDTH-1:0] inflight_pc_q;
    logic [AW:0]      used;
    logic             enq, deq;

    // An in-flight request already owns a slot, so count it against the credit.
    assign used = count_q + {{AW{1'b0}}, inflight_q};

    always_comb begin
        imem_req    = !reset && !flush && (used < DEPTH_W);
        pc_stall    = !imem_req;
        imem_addr   = pc;
        instr_valid = (count_q != '0);
        instr       = instr_mem[rd_ptr_q];
        instr_pc    = pc_mem[rd_ptr_q];
        enq         = inflight_q && !flush;
        deq         = instr_valid && instr_ready;
    end

    always_comb begin
        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + ONE_W;
        end else if (!enq && deq) begin
            count_d = count_q - ONE_W;
        end
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            inflight_q    <= imem_req;
            inflight_pc_q <= pc;
            count_q       <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (enq) begin
                    instr_mem[wr_ptr_q] <= imem_rdata;
                    pc_mem[wr_ptr_q]    <= inflight_pc_q;
                    wr_ptr_q            <= wr_ptr_q + 1'b1;
                end
                if (deq) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue. The bench models the PC, which advances
// whenever pc_stall is low, and a one-cycle-latency instruction memory that returns
// 32'hA000_0000 + addr.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        pc_stall;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_queue #(.WIDTH(32), .DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .pc_stall    (pc_stall),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .instr_ready (instr_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: the memory returns data for the address presented before the edge,
    // and the PC advances if no stall was seen.
    task automatic tick();
        logic [31:0] a;
        logic        adv;
        #1;
        a   = imem_addr;
        adv = !pc_stall;
        @(posedge clk);
        #1;
        imem_rdata = 32'hA000_0000 + a;
        if (adv) pc = pc + 1;
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset = 1'b1;
        flush = 1'b0;
        tick();
        tick();
        pc    = start_pc;
        reset = 1'b0;
        settle();
    endtask

    initial begin
        int          nreq;
        int          exp_pc;
        bit          found;
        reset       = 1'b1;
        pc          = 0;
        flush       = 1'b0;
        imem_rdata  = 0;
        instr_ready = 1'b1;

        // Reset state and streaming at full rate.
        tick();
        tick();
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_stall", 32'(pc_stall), 1);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        reset = 1'b0;
        settle();
        check("s_req0", 32'(imem_req), 1);
        check("s_addr0", imem_addr, 0);
        tick();
        check("s_lat_valid_c1", 32'(instr_valid), 0);
        tick();
        check("s_lat_valid_c2", 32'(instr_valid), 1);
        check("s_instr0", instr, 32'hA000_0000);
        check("s_pc0", instr_pc, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("s_instr", instr, 32'hA000_0000 + 32'(k));
            check("s_pc", instr_pc, 32'(k));
            check("s_stall", 32'(pc_stall), 0);
        end

        // Back-pressure: exactly DEPTH requests, then drain in order.
        instr_ready = 1'b0;
        do_reset(0);
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) nreq++;
            tick();
        end
        check("bp_nreq", 32'(nreq), 4);
        check("bp_stall", 32'(pc_stall), 1);
        check("bp_req", 32'(imem_req), 0);
        check("bp_pc_held", pc, 4);
        instr_ready = 1'b1;
        settle();
        for (int k = 0; k < 8; k++) begin
            check("bp_valid", 32'(instr_valid), 1);
            check("bp_order", instr_pc, 32'(k));
            if (k == 1) check("bp_resume_req", 32'(imem_req), 1);
            tick();
        end

        // Flush in the cycle after the request for addr 5.
        do_reset(0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 5) found = 1'b1;
            else tick();
        end
        check("fl_found5", 32'(found), 1);
        tick();
        flush = 1'b1;
        settle();
        check("fl_req_F", 32'(imem_req), 0);
        check("fl_stall_F", 32'(pc_stall), 1);
        tick();
        flush = 1'b0;
        pc    = 32'h40;
        settle();
        check("fl_valid_F1", 32'(instr_valid), 0);
        check("fl_req_F1", 32'(imem_req), 1);
        tick();
        check("fl_valid_F2", 32'(instr_valid), 0);
        tick();
        check("fl_valid_F3", 32'(instr_valid), 1);
        check("fl_target_pc", instr_pc, 32'h40);
        check("fl_target_instr", instr, 32'hA000_0040);

        // Full queue with random ready: no loss, no duplication, in order.
        instr_ready = 1'b0;
        do_reset(0);
        for (int i = 0; i < 6; i++) tick();
        exp_pc = 0;
        for (int i = 0; i < 30; i++) begin
            instr_ready = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            settle();
            if (instr_valid && instr_ready) begin
                check("rr_order", instr_pc, 32'(exp_pc));
                check("rr_data", instr, 32'hA000_0000 + 32'(exp_pc));
                exp_pc++;
            end
            tick();
        end
        check("rr_progress", 32'(exp_pc >= 10), 1);

        // Reset and flush together with count = 3.
        instr_ready = 1'b0;
        do_reset(0);
        for (int i = 0; i < 4; i++) tick();
        check("rf_valid_before", 32'(instr_valid), 1);
        reset = 1'b1;
        flush = 1'b1;
        tick();
        check("rf_valid", 32'(instr_valid), 0);
        check("rf_stall", 32'(pc_stall), 1);
        check("rf_req", 32'(imem_req), 0);
        reset       = 1'b0;
        flush       = 1'b0;
        pc          = 32'h100;
        instr_ready = 1'b1;
        settle();
        check("rf_restart_addr", imem_addr, 32'h100);
        tick();
        tick();
        check("rf_restart_valid", 32'(instr_valid), 1);
        check("rf_restart_pc", instr_pc, 32'h100);
        check("rf_restart_instr", instr, 32'hA000_0100);

`ifdef FETCH_PERF_EN
        // Stall cycles c4..c7 plus the three flush cycles; reset cycles are excluded.
        instr_ready = 1'b0;
        do_reset(0);
        check("pf_stall_rst", perf_stall_cnt, 0);
        check("pf_flush_rst", perf_flush_cnt, 0);
        for (int i = 0; i < 8; i++) tick();
        for (int p = 0; p < 3; p++) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            tick();
        end
        check("pf_stall_cnt", perf_stall_cnt, 7);
        check("pf_flush_cnt", perf_flush_cnt, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
